// File: rtl/instr_encoder.sv
// Packs decoded RV32I instruction fields back into 32-bit words and streams
// them into instruction memory through a small FIFO and an auto-incrementing write port.
module instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        type_i,
    input  logic [6:0]        op_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [19:0]       imm_i,
    input  logic              addr_load_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              imem_we_o,
    input  logic              imem_ready_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              err_o,
    input  logic              clr_err_i,
    output logic [15:0]       words_o,
    output logic              busy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    function automatic logic is_legal(input logic [2:0] typ, input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (typ)
            3'd0:    ok = (op == 7'b0110011);
            3'd1:    ok = (op == 7'b0000011) || (op == 7'b0010011) || (op == 7'b1100111);
            3'd2:    ok = (op == 7'b0100011);
            3'd3:    ok = (op == 7'b1100011);
            3'd4:    ok = (op == 7'b0110111) || (op == 7'b0010111);
            3'd5:    ok = (op == 7'b1101111);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Immediates arrive in the decoder's compressed layout, so B and J are re-scrambled here.
    function automatic logic [31:0] encode(
        input logic [2:0]  typ,
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [19:0] imm
    );
        logic [31:0] w;
        w = 32'd0;
        case (typ)
            3'd0:    w = {f7, rs2, rs1, f3, rd, op};
            3'd1:    w = {imm[11:0], rs1, f3, rd, op};
            3'd2:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            3'd3:    w = {imm[11], imm[9:4], rs2, rs1, f3, imm[3:0], imm[10], op};
            3'd4:    w = {imm[19:0], rd, op};
            3'd5:    w = {imm[19], imm[9:0], imm[10], imm[18:11], rd, op};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    logic [31:0]       mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       words_r;
    logic              err_r;

    logic              full_s;
    logic              empty_s;
    logic              accept_s;
    logic              legal_s;
    logic              push_s;
    logic              pop_s;
    logic              illegal_s;
    logic [31:0]       enc_word_s;

    // Handshake, legality and FIFO control decode.
    always_comb begin
        full_s     = (count_r == CNT_W'(DEPTH));
        empty_s    = (count_r == {CNT_W{1'b0}});
        accept_s   = req_valid_i && !full_s;
        legal_s    = is_legal(type_i, op_i);
        push_s     = accept_s && legal_s;
        illegal_s  = accept_s && !legal_s;
        pop_s      = !empty_s && imem_ready_i;
        enc_word_s = encode(type_i, op_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i);
    end

    // FIFO storage, pointers and occupancy; no bypass, so a full FIFO refuses pushes even while popping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= enc_word_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Write address and completed-write counter; a load overrides the increment.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_r  <= {ADDR_W{1'b0}};
            words_r <= 16'd0;
        end else begin
            if (addr_load_i) begin
                addr_r <= addr_i;
            end else if (pop_s) begin
                addr_r <= addr_r + ADDR_W'(1);
            end
            if (pop_s) begin
                words_r <= words_r + 16'd1;
            end
        end
    end

    // Sticky error: a same-cycle illegal accept beats the clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_r <= 1'b0;
        end else if (illegal_s) begin
            err_r <= 1'b1;
        end else if (clr_err_i) begin
            err_r <= 1'b0;
        end
    end

    // Output mapping straight from state.
    always_comb begin
        req_ready_o  = !full_s;
        imem_we_o    = !empty_s;
        busy_o       = !empty_s;
        imem_wdata_o = empty_s ? 32'd0 : mem_r[rd_ptr_r];
        imem_addr_o  = addr_r;
        words_o      = words_r;
        err_o        = err_r;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued as requests are
// driven and popped by a write monitor as the memory port completes writes.
module tb_instr_encoder;

    logic        clk_i;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  type_i;
    logic [6:0]  op_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [19:0] imm_i;
    logic        addr_load_i;
    logic [9:0]  addr_i;
    logic        imem_we_o;
    logic        imem_ready_i;
    logic [9:0]  imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic        err_o;
    logic        clr_err_i;
    logic [15:0] words_o;
    logic        busy_o;

    int          vectors;
    int          miscompares;
    logic [31:0] sb_q[$];
    logic [9:0]  tb_addr;
    logic [31:0] exp_word;

    instr_encoder #(.ADDR_W(10), .DEPTH(2)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .type_i(type_i), .op_i(op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .addr_load_i(addr_load_i), .addr_i(addr_i),
        .imem_we_o(imem_we_o), .imem_ready_i(imem_ready_i),
        .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
        .err_o(err_o), .clr_err_i(clr_err_i),
        .words_o(words_o), .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Write monitor: every completed write must match the scoreboard head and the modelled address.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (imem_we_o && imem_ready_i) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_write got data %08h addr %03h, required no write", imem_wdata_o, imem_addr_o);
                end else begin
                    exp_word = sb_q.pop_front();
                    if (imem_wdata_o !== exp_word || imem_addr_o !== tb_addr) begin
                        miscompares++;
                        $display("FAIL mem_write got %08h@%03h required %08h@%03h", imem_wdata_o, imem_addr_o, exp_word, tb_addr);
                    end
                end
                tb_addr = tb_addr + 10'd1;
            end
            if (addr_load_i) tb_addr = addr_i;
        end
    end

    task automatic drive_req(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [19:0] imm);
        req_valid_i = 1'b1; type_i = t; op_i = op; funct3_i = f3; funct7_i = f7;
        rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    endtask

    task automatic idle_req();
        req_valid_i = 1'b0; type_i = 3'd0; op_i = 7'd0; funct3_i = 3'd0; funct7_i = 7'd0;
        rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0; imm_i = 20'd0;
    endtask

    task automatic apply_reset();
        idle_req();
        addr_load_i = 1'b0; addr_i = 10'd0; clr_err_i = 1'b0;
        reset_i = 1'b1;
        sb_q.delete();
        tb_addr = 10'd0;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (imem_we_o !== 1'b0)      begin miscompares++; $display("FAIL reset_we got %0h required 0", imem_we_o); end
        vectors++; if (busy_o !== 1'b0)         begin miscompares++; $display("FAIL reset_busy got %0h required 0", busy_o); end
        vectors++; if (req_ready_o !== 1'b1)    begin miscompares++; $display("FAIL reset_ready got %0h required 1", req_ready_o); end
        vectors++; if (imem_wdata_o !== 32'd0)  begin miscompares++; $display("FAIL reset_wdata got %08h required 0", imem_wdata_o); end
        vectors++; if (imem_addr_o !== 10'd0)   begin miscompares++; $display("FAIL reset_addr got %03h required 0", imem_addr_o); end
        vectors++; if (words_o !== 16'd0)       begin miscompares++; $display("FAIL reset_words got %0d required 0", words_o); end
        vectors++; if (err_o !== 1'b0)          begin miscompares++; $display("FAIL reset_err got %0h required 0", err_o); end
    endtask

    task automatic test_r_type();
        apply_reset();
        imem_ready_i = 1'b1;
        drive_req(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 20'd0);
        sb_q.push_back(32'h002081B3);
        @(posedge clk_i); #1;
        idle_req();
        vectors++; if (imem_we_o !== 1'b1)            begin miscompares++; $display("FAIL r_latency_we got %0h required 1", imem_we_o); end
        vectors++; if (imem_wdata_o !== 32'h002081B3) begin miscompares++; $display("FAIL r_latency_wdata got %08h required 002081b3", imem_wdata_o); end
        @(posedge clk_i); #1;
        vectors++; if (words_o !== 16'd1)  begin miscompares++; $display("FAIL r_words got %0d required 1", words_o); end
        vectors++; if (busy_o !== 1'b0)    begin miscompares++; $display("FAIL r_busy got %0h required 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        imem_ready_i = 1'b1;
        drive_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 20'h00FFF); sb_q.push_back(32'hFFF00293);
        @(posedge clk_i); #1;
        drive_req(3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'h12345); sb_q.push_back(32'h123450B7);
        @(posedge clk_i); #1;
        vectors++; if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %0h required 1", req_ready_o); end
        drive_req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 20'h00FFF); sb_q.push_back(32'hFE000FE3);
        @(posedge clk_i); #1;
        drive_req(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 20'hFFFFF); sb_q.push_back(32'hFFFFF06F);
        @(posedge clk_i); #1;
        idle_req();
        @(posedge clk_i); #1;
        vectors++; if (words_o !== 16'd4)        begin miscompares++; $display("FAIL b2b_words got %0d required 4", words_o); end
        vectors++; if (imem_addr_o !== 10'd4)    begin miscompares++; $display("FAIL b2b_addr got %03h required 004", imem_addr_o); end
        vectors++; if (busy_o !== 1'b0)          begin miscompares++; $display("FAIL b2b_busy got %0h required 0", busy_o); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        imem_ready_i = 1'b0;
        drive_req(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 20'd0); sb_q.push_back(32'h003100B3);
        @(posedge clk_i); #1;
        vectors++; if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_ready1 got %0h required 1", req_ready_o); end
        drive_req(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd6, 5'd5, 20'h00123); sb_q.push_back(32'h125321A3);
        @(posedge clk_i); #1;
        vectors++; if (req_ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready got %0h required 0", req_ready_o); end
        drive_req(3'd1, 7'h03, 3'd2, 7'd0, 5'd8, 5'd7, 5'd0, 20'h00800); sb_q.push_back(32'h8003A403);
        repeat (2) @(posedge clk_i);
        #1;
        vectors++; if (imem_we_o !== 1'b1 || imem_wdata_o !== 32'h003100B3 || imem_addr_o !== 10'd0) begin
            miscompares++; $display("FAIL bp_stall got we=%0h %08h@%03h required we=1 003100b3@000", imem_we_o, imem_wdata_o, imem_addr_o);
        end
        vectors++; if (words_o !== 16'd0)    begin miscompares++; $display("FAIL bp_stall_words got %0d required 0", words_o); end
        imem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        vectors++; if (req_ready_o !== 1'b1 || imem_wdata_o !== 32'h125321A3) begin
            miscompares++; $display("FAIL bp_no_bypass got ready=%0h wdata=%08h required ready=1 wdata=125321a3", req_ready_o, imem_wdata_o);
        end
        @(posedge clk_i); #1;
        idle_req();
        @(posedge clk_i); #1;
        vectors++; if (words_o !== 16'd3)     begin miscompares++; $display("FAIL bp_words got %0d required 3", words_o); end
        vectors++; if (req_ready_o !== 1'b1)  begin miscompares++; $display("FAIL bp_ready_end got %0h required 1", req_ready_o); end
        vectors++; if (busy_o !== 1'b0)       begin miscompares++; $display("FAIL bp_busy_end got %0h required 0", busy_o); end
    endtask

    task automatic test_illegal();
        apply_reset();
        imem_ready_i = 1'b1;
        drive_req(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 20'd0);
        vectors++; if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL ill_ready got %0h required 1", req_ready_o); end
        @(posedge clk_i); #1;
        vectors++; if (err_o !== 1'b1 || imem_we_o !== 1'b0) begin
            miscompares++; $display("FAIL ill_opcode got err=%0h we=%0h required err=1 we=0", err_o, imem_we_o);
        end
        drive_req(3'd6, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 20'd0);
        @(posedge clk_i); #1;
        vectors++; if (err_o !== 1'b1 || imem_we_o !== 1'b0) begin
            miscompares++; $display("FAIL ill_type got err=%0h we=%0h required err=1 we=0", err_o, imem_we_o);
        end
        idle_req();
        clr_err_i = 1'b1;
        @(posedge clk_i); #1;
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL ill_clear got %0h required 0", err_o); end
        drive_req(3'd7, 7'h33, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 20'd0);
        @(posedge clk_i); #1;
        vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL ill_set_wins got %0h required 1", err_o); end
        clr_err_i = 1'b0;
        idle_req();
        vectors++; if (words_o !== 16'd0) begin miscompares++; $display("FAIL ill_words got %0d required 0", words_o); end
    endtask

    task automatic test_addr_wrap();
        apply_reset();
        imem_ready_i = 1'b1;
        addr_load_i = 1'b1; addr_i = 10'h3FF;
        @(posedge clk_i); #1;
        addr_load_i = 1'b0;
        vectors++; if (imem_addr_o !== 10'h3FF) begin miscompares++; $display("FAIL addr_load got %03h required 3ff", imem_addr_o); end
        drive_req(3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'h00001); sb_q.push_back(32'h000010B7);
        @(posedge clk_i); #1;
        drive_req(3'd4, 7'h17, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 20'hABCDE); sb_q.push_back(32'hABCDE117);
        @(posedge clk_i); #1;
        idle_req();
        @(posedge clk_i); #1;
        vectors++; if (imem_addr_o !== 10'h001) begin miscompares++; $display("FAIL addr_wrap got %03h required 001", imem_addr_o); end
        drive_req(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'h12345); sb_q.push_back(32'h68A240EF);
        @(posedge clk_i); #1;
        addr_load_i = 1'b1; addr_i = 10'h100;
        drive_req(3'd0, 7'h33, 3'd0, 7'h20, 5'd10, 5'd11, 5'd12, 20'd0); sb_q.push_back(32'h40C58533);
        @(posedge clk_i); #1;
        addr_load_i = 1'b0;
        idle_req();
        @(posedge clk_i); #1;
        vectors++; if (imem_addr_o !== 10'h101) begin miscompares++; $display("FAIL addr_load_collide got %03h required 101", imem_addr_o); end
        vectors++; if (words_o !== 16'd4)      begin miscompares++; $display("FAIL addr_words got %0d required 4", words_o); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        imem_ready_i = 1'b1;
        drive_req(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 20'd0); sb_q.push_back(32'h003100B3);
        @(posedge clk_i); #1;
        idle_req();
        @(posedge clk_i); #1;
        imem_ready_i = 1'b0;
        drive_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 20'h00FFF);
        @(posedge clk_i); #1;
        drive_req(3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'h12345);
        @(posedge clk_i); #1;
        idle_req();
        vectors++; if (req_ready_o !== 1'b0 || words_o !== 16'd1) begin
            miscompares++; $display("FAIL mid_pre got ready=%0h words=%0d required ready=0 words=1", req_ready_o, words_o);
        end
        reset_i = 1'b1;
        sb_q.delete();
        tb_addr = 10'd0;
        #1;
        vectors++; if (imem_we_o !== 1'b0 || busy_o !== 1'b0 || words_o !== 16'd0 || imem_addr_o !== 10'd0) begin
            miscompares++; $display("FAIL mid_async got we=%0h busy=%0h words=%0d addr=%03h required all 0", imem_we_o, busy_o, words_o, imem_addr_o);
        end
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        imem_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        vectors++; if (words_o !== 16'd0 || busy_o !== 1'b0) begin
            miscompares++; $display("FAIL mid_stale got words=%0d busy=%0h required 0 0", words_o, busy_o);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; tb_addr = 10'd0;
        reset_i = 1'b1; imem_ready_i = 1'b0;
        idle_req();
        addr_load_i = 1'b0; addr_i = 10'd0; clr_err_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        reset_i = 1'b0;
        test_r_type();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_addr_wrap();
        test_reset_mid();
        vectors++; if (sb_q.size() != 0) begin miscompares++; $display("FAIL sb_drain got %0d pending required 0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
